decode_stage: RTL and testbench

Decode/operand-fetch stage of the PA pipeline, directly upstream of the execution stage. Accepts 32-bit instructions from fetch via a valid/ready handshake, splits fields, reads two operands from a 32×32 register file with a writeback port, and drives the execution stage inputs `opcode`, `dst`, `src1`, `src2` and `offsetlo` from registers. Holds a multiply on its outputs for the full multiply latency, stalling fetch meanwhile, and inserts NOP bubbles when fetch has nothing valid.

---
 rtl/pa_pkg.sv | 49 ++++
 rtl/decode_stage_if.sv | 11 +
 rtl/decode_stage_reg_file.sv | 45 ++++
 rtl/decode_stage.sv | 123 ++++++++++++
 tb/tb_decode_stage.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pa_pkg.sv
// Shared definitions for the PA pipeline: opcodes, instruction field layout,
// decoded-field payload and the multiply latency shared with execution.
package pa_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned OFF_W     = 10;
    localparam int unsigned NUM_REGS  = 32;

    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned DST_LSB = 21;
    localparam int unsigned RS1_LSB = 16;
    localparam int unsigned RS2_LSB = 11;
    localparam int unsigned OFF_LSB = 0;

    localparam int unsigned MUL_CYCLES_DEF = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 6'h00;
    localparam logic [OPC_W-1:0] OP_SUB = 6'h01;
    localparam logic [OPC_W-1:0] OP_MUL = 6'h02;
    localparam logic [OPC_W-1:0] OP_NOP = 6'h3F;

    typedef enum logic {
        ST_ISSUE    = 1'b0,
        ST_MUL_HOLD = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [REG_IDX_W-1:0] dst;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [OFF_W-1:0]     offsetlo;
    } dec_fields_t;

    // Split an instruction word into its fields; bit 10 carries no meaning.
    function automatic dec_fields_t decode_instr(input logic [INSTR_W-1:0] instr);
        dec_fields_t f;
        f.opcode   = instr[OPC_LSB +: OPC_W];
        f.dst      = instr[DST_LSB +: REG_IDX_W];
        f.rs1      = instr[RS1_LSB +: REG_IDX_W];
        f.rs2      = instr[RS2_LSB +: REG_IDX_W];
        f.offsetlo = instr[OFF_LSB +: OFF_W];
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode instruction handshake.
interface decode_stage_if;

    logic                        in_valid;
    logic [pa_pkg::INSTR_W-1:0]  in_instr;
    logic                        in_ready;

    modport master (output in_valid, output in_instr, input  in_ready);
    modport slave  (input  in_valid, input  in_instr, output in_ready);

endinterface

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: two combinational read ports with writeback bypass,
// one synchronous write port, r0 hardwired to zero.
module reg_file
    import pa_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata1_c,
    output logic [DATA_W-1:0]    rdata2_c
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // A same-cycle write to the addressed register is forwarded to the reader.
    always_comb begin
        rdata1_c = mem_q[raddr1];
        rdata2_c = mem_q[raddr2];
        if (we && (waddr == raddr1)) rdata1_c = wdata;
        if (we && (waddr == raddr2)) rdata2_c = wdata;
        if (raddr1 == '0) rdata1_c = '0;
        if (raddr2 == '0) rdata2_c = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// PA decode/operand-fetch stage: registers decoded fields and operands for
// execution, freezes them for the full multiply latency, and issues bubbles.
module decode_stage
    import pa_pkg::*;
#(
    parameter int unsigned      MUL_CYCLES = MUL_CYCLES_DEF,
    parameter logic [OPC_W-1:0] NOP_OPCODE = OP_NOP
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_stage_if.slave        fetch,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [OPC_W-1:0]     opcode,
    output logic [REG_IDX_W-1:0] dst,
    output logic [DATA_W-1:0]    src1,
    output logic [DATA_W-1:0]    src2,
    output logic [OFF_W-1:0]     offsetlo,
    output logic                 out_valid
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    dec_state_e           state_q,     state_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic [OPC_W-1:0]     opcode_q,    opcode_d;
    logic [REG_IDX_W-1:0] dst_q,       dst_d;
    logic [DATA_W-1:0]    src1_q,      src1_d;
    logic [DATA_W-1:0]    src2_q,      src2_d;
    logic [OFF_W-1:0]     offsetlo_q,  offsetlo_d;
    logic                 out_valid_q, out_valid_d;

    dec_fields_t       fld;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              unused_instr_bit10;

    assign fld                = decode_instr(fetch.in_instr);
    assign unused_instr_bit10 = fetch.in_instr[10];

    reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_en),
        .waddr    (wb_addr),
        .wdata    (wb_data),
        .raddr1   (fld.rs1),
        .raddr2   (fld.rs2),
        .rdata1_c (rdata1),
        .rdata2_c (rdata2)
    );

    assign fetch.in_ready = !rst && (state_q == ST_ISSUE);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        opcode_d    = opcode_q;
        dst_d       = dst_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        offsetlo_d  = offsetlo_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_ISSUE: begin
                if (fetch.in_valid) begin
                    opcode_d    = fld.opcode;
                    dst_d       = fld.dst;
                    src1_d      = rdata1;
                    src2_d      = rdata2;
                    offsetlo_d  = fld.offsetlo;
                    out_valid_d = 1'b1;
                    if (fld.opcode == OP_MUL) begin
                        state_d = ST_MUL_HOLD;
                        count_d = '0;
                    end
                end else begin
                    // Bubble: only opcode and valid change, payload is left as-is.
                    opcode_d    = NOP_OPCODE;
                    out_valid_d = 1'b0;
                end
            end
            ST_MUL_HOLD: begin
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(MUL_CYCLES - 2)) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ISSUE;
            count_q     <= '0;
            opcode_q    <= NOP_OPCODE;
            dst_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            offsetlo_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            opcode_q    <= opcode_d;
            dst_q       <= dst_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            offsetlo_q  <= offsetlo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign opcode    = opcode_q;
    assign dst       = dst_q;
    assign src1      = src1_q;
    assign src2      = src2_q;
    assign offsetlo  = offsetlo_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_decode_stage;
    import pa_pkg::*;

    localparam int unsigned MULC = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  opcode;
    logic [4:0]  dst;
    logic [31:0] src1, src2;
    logic [9:0]  offsetlo;
    logic        out_valid;

    always #5 clk = ~clk;

    decode_stage_if fif ();

    decode_stage #(.MUL_CYCLES(MULC), .NOP_OPCODE(6'h3F)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fif),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .opcode    (opcode),
        .dst       (dst),
        .src1      (src1),
        .src2      (src2),
        .offsetlo  (offsetlo),
        .out_valid (out_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: register array, expected output values and the
    // number of upcoming cycles during which fetch is refused.
    logic [31:0] m_regs [32];
    int          m_block;
    logic [5:0]  e_op;
    logic [4:0]  e_dst;
    logic [31:0] e_s1, e_s2;
    logic [9:0]  e_off;
    logic        e_v;
    bit          armed = 0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic model_step();
        logic [31:0] ins;
        ins = fif.in_instr;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_block = 0;
            e_op = 6'h3F; e_dst = 5'd0; e_s1 = 32'd0; e_s2 = 32'd0; e_off = 10'd0; e_v = 1'b0;
        end else begin
            if (m_block == 0) begin
                if (fif.in_valid) begin
                    e_op  = ins[31:26];
                    e_dst = ins[25:21];
                    e_s1  = m_read(ins[20:16]);
                    e_s2  = m_read(ins[15:11]);
                    e_off = ins[9:0];
                    e_v   = 1'b1;
                    if (ins[31:26] == 6'h02) m_block = MULC - 1;
                end else begin
                    e_op = 6'h3F;
                    e_v  = 1'b0;
                end
            end else begin
                m_block--;
            end
            if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [31:0] ins,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        if (armed) begin
            check_eq("opcode",    32'(opcode),    32'(e_op));
            check_eq("dst",       32'(dst),       32'(e_dst));
            check_eq("src1",      src1,           e_s1);
            check_eq("src2",      src2,           e_s2);
            check_eq("offsetlo",  32'(offsetlo),  32'(e_off));
            check_eq("out_valid", 32'(out_valid), 32'(e_v));
        end
        rst          = r;
        fif.in_valid = v;
        fif.in_instr = ins;
        wb_en        = we;
        wb_addr      = wa;
        wb_data      = wd;
        #1;
        if (armed) check_eq("in_ready", 32'(fif.in_ready), 32'(!r && m_block == 0));
        model_step();
        armed = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] a, input logic [4:0] b,
                                       input logic [9:0] off);
        return {op, d, a, b, 1'b0, off};
    endfunction

    logic [31:0] add_i, mul_i;
    logic        rv, rr, rwe;
    logic [31:0] rins;

    initial begin
        rst = 1'b1; fif.in_valid = 1'b0; fif.in_instr = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset and basic ADD
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("rst_opcode", 32'(opcode), 32'h3F);
        check_eq("rst_valid",  32'(out_valid), 32'd0);
        check_eq("rst_ready",  32'(fif.in_ready), 32'd0);
        cycle(0, 0, 0, 1, 5'd3, 32'd5);
        cycle(0, 0, 0, 1, 5'd4, 32'd7);
        add_i = mk(6'h00, 5'd1, 5'd3, 5'd4, 10'd0);
        cycle(0, 1, add_i, 0, 0, 0);
        check_eq("add_src1", src1, 32'd5);
        check_eq("add_src2", src2, 32'd7);
        check_eq("add_dst",  32'(dst), 32'd1);

        // MUL with an ADD waiting behind it
        mul_i = mk(6'h02, 5'd2, 5'd3, 5'd4, 10'd0);
        cycle(0, 1, mul_i, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            check_eq("mul_hold_op", 32'(opcode), 32'h02);
            cycle(0, 1, add_i, 1, 5'd4, 32'd100);
        end
        check_eq("mul_last_op", 32'(opcode), 32'h02);
        check_eq("mul_src2_frozen", src2, 32'd7);
        cycle(0, 1, add_i, 0, 0, 0);
        check_eq("after_mul_op",   32'(opcode), 32'h00);
        check_eq("after_mul_src2", src2, 32'd100);

        // Bypass and r0
        cycle(0, 1, mk(6'h01, 5'd6, 5'd5, 5'd0, 10'd0), 1, 5'd5, 32'hDEADBEEF);
        check_eq("bypass_src1", src1, 32'hDEADBEEF);
        cycle(0, 0, 0, 1, 5'd0, 32'h1234);
        cycle(0, 1, mk(6'h00, 5'd7, 5'd0, 5'd5, 10'd0), 0, 0, 0);
        check_eq("r0_src1", src1, 32'd0);
        check_eq("r5_src2", src2, 32'hDEADBEEF);

        // Bubble, pass-through opcode, full offset
        cycle(0, 0, 0, 0, 0, 0);
        check_eq("bubble_op", 32'(opcode), 32'h3F);
        check_eq("bubble_v",  32'(out_valid), 32'd0);
        cycle(0, 1, mk(6'h2A, 5'd9, 5'd3, 5'd5, 10'h3FF) | 32'h400, 0, 0, 0);
        check_eq("pass_op",  32'(opcode), 32'h2A);
        check_eq("pass_v",   32'(out_valid), 32'd1);
        check_eq("pass_off", 32'(offsetlo), 32'h3FF);

        // Reset in the third hold cycle
        cycle(0, 1, mul_i, 0, 0, 0);
        cycle(0, 1, mul_i, 0, 0, 0);
        cycle(0, 1, mul_i, 0, 0, 0);
        cycle(1, 1, mul_i, 0, 0, 0);
        check_eq("rst_hold_op",  32'(opcode), 32'h3F);
        check_eq("rst_hold_s1",  src1, 32'd0);
        cycle(0, 1, mk(6'h00, 5'd8, 5'd3, 5'd0, 10'd0), 1, 5'd3, 32'd9);
        check_eq("post_rst_op", 32'(opcode), 32'h00);
        check_eq("post_rst_s1", src1, 32'd9);

        // Random traffic; fetch keeps its request stable while refused
        rv = 1'b0; rins = '0;
        for (int n = 0; n < 1500; n++) begin
            rr = ($urandom_range(0, 79) == 0);
            if (m_block == 0 || !rv) begin
                int sel;
                logic [5:0] op;
                rv  = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 9);
                op  = (sel < 3) ? 6'h00 : (sel < 5) ? 6'h01 : (sel < 7) ? 6'h02 :
                      (sel < 8) ? 6'h3F : 6'($urandom);
                rins = mk(op, 5'($urandom), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 10'($urandom)) | (32'($urandom_range(0, 1)) << 10);
            end
            rwe = ($urandom_range(0, 1) == 1);
            cycle(rr, rv, rins, rwe, 5'($urandom_range(0, 7)), $urandom);
        end
        cycle(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
